// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DEF_WIDTH : default operand / quotient / remainder width
//   S_IDLE, S_RUN, S_DONE : FSM state encodings
//   state_t   : enumerated FSM state type built on those encodings
package divisor_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division step (combinational).
//   i_p    : current partial remainder (always < divisor, so WIDTH bits suffice)
//   i_bit  : next dividend bit, MSB first
//   i_div  : divisor
//   o_p    : partial remainder after the step
//   o_qbit : quotient bit produced by the step
module divisor_passo
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_p,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  // The shifted remainder needs one extra bit before the compare.
  assign w_shift = {i_p, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_div});

  // After a successful subtract the result is < divisor, so dropping the
  // top bit loses nothing. With divisor 0 the shifted value never grows
  // past WIDTH bits because P starts at zero and takes at most WIDTH shifts.
  assign o_p    = w_ge ? WIDTH'(w_shift - {1'b0, i_div}) : w_shift[WIDTH-1:0];
  assign o_qbit = w_ge;

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: unsigned a / b, one quotient bit per clock.
// Shares the start/busy/valid handshake of the shift-add multiplier.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request a division (accepted only when busy == 0)
//   a, b     : dividend / divisor, sampled on the accepting edge
//   busy     : high while iterating
//   valid    : q/r hold the result of the last accepted request
//   q, r     : quotient / remainder (0 unless valid)
//   div_zero : divide-by-zero flag, present only with DIVISOR_DBZ_EN
// Optional build macro: DIVISOR_DBZ_EN -- a zero divisor completes on the
// accepting edge with div_zero=1 instead of running the iterations.
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q,
`ifdef DIVISOR_DBZ_EN
  output logic [WIDTH-1:0] r,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] r
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_valid;
`ifdef DIVISOR_DBZ_EN
  logic            r_dz;
`endif

  logic [WIDTH-1:0] r_d;   // dividend, shifted left one bit per step
  logic [WIDTH-1:0] r_b;   // latched divisor
  logic [WIDTH-1:0] r_p;   // partial remainder
  logic [WIDTH-1:0] r_q;   // quotient, filled from the LSB

  logic             w_accept;
  logic [WIDTH-1:0] w_p_next;
  logic             w_qbit;

  assign w_accept = start && (r_state != ST_RUN);

  divisor_passo #(.WIDTH(WIDTH)) u_passo (
    .i_p    (r_p),
    .i_bit  (r_d[WIDTH-1]),
    .i_div  (r_b),
    .o_p    (w_p_next),
    .o_qbit (w_qbit)
  );

  // Control: FSM, step counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef DIVISOR_DBZ_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
`ifdef DIVISOR_DBZ_EN
            r_dz    <= 1'b0;
            if (b == '0) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
              r_dz    <= 1'b1;
            end
`endif
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: no reset needed, outputs are gated by r_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_d <= a;
      r_b <= b;
      r_p <= '0;
      r_q <= '0;
`ifdef DIVISOR_DBZ_EN
      if (b == '0) begin
        r_q <= '1;
        r_p <= a;
      end
`endif
    end else if (r_state == ST_RUN) begin
      r_d <= r_d << 1;
      r_p <= w_p_next;
      r_q <= {r_q[WIDTH-2:0], w_qbit};
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign q     = r_valid ? r_q : '0;
  assign r     = r_valid ? r_p : '0;
`ifdef DIVISOR_DBZ_EN
  assign div_zero = r_dz;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial (WIDTH=4). Build with or without
// DIVISOR_DBZ_EN; the divide-by-zero expectations follow the macro.
module tb_divisor_sequencial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       valid;
  logic [3:0] q;
  logic [3:0] r;
`ifdef DIVISOR_DBZ_EN
  logic       div_zero;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  divisor_sequencial #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .valid    (valid),
    .q        (q),
`ifdef DIVISOR_DBZ_EN
    .r        (r),
    .div_zero (div_zero)
`else
    .r        (r)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge after acceptance.
  task automatic issue(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] eq, input logic [3:0] er, input bit push);
    exp_t e;
    int   guard = 0;
    int   lat = 4;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check({tag, "_wait_idle"}, 1, 0);
`ifdef DIVISOR_DBZ_EN
    if (ib == 4'd0) lat = 0;
`endif
    start = 1'b1;
    a = ia;
    b = ib;
    if (push) begin
      e.tag = tag; e.a = ia; e.b = ib; e.q = eq; e.r = er;
      e.dz = (lat == 0);
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_drain_timeout"}, int'(sb.size() != 0 || busy), 0);
  endtask

  // Monitor: compare each new result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_q"}, int'(q), int'(e.q));
          check({e.tag, "_r"}, int'(r), int'(e.r));
          check({e.tag, "_lat_edge"}, cyc, e.cyc);
          check({e.tag, "_busy_at_valid"}, int'(busy), 0);
`ifdef DIVISOR_DBZ_EN
          check({e.tag, "_dz"}, int'(div_zero), int'(e.dz));
`endif
          if (e.b != 4'd0) begin
            check({e.tag, "_identity"},
                  int'((int'(q) * int'(e.b) + int'(r) == int'(e.a)) && (r < e.b)), 1);
          end
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
`ifdef DIVISOR_DBZ_EN
    check("rst_dz", int'(div_zero), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 7/2, busy for 4 cycles with q/r at 0
    issue("t1_7_2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t1_busy", int'(busy), 1);
      check("t1_valid_low", int'(valid), 0);
      check("t1_q_zero", int'(q), 0);
      check("t1_r_zero", int'(r), 0);
      @(negedge clk);
    end
    check("t1_valid_high", int'(valid), 1);
    drain("t1");

    // 2: back-to-back
    issue("t2_3_8", 4'd3, 4'd8, 4'd0, 4'd3, 1'b1);
    issue("t2_15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b1);
    issue("t2_15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b1);
    drain("t2");

    // 3: start during RUN is ignored
    issue("t3_9_4", 4'd9, 4'd4, 4'd2, 4'd1, 1'b1);
    start = 1'b1; a = 4'd1; b = 4'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain("t3");
    repeat (3) @(negedge clk);
    check("t3_no_second_result", int'(valid && q == 4'd2 && r == 4'd1), 1);

    // 3b: start held high across the result edge relaunches from DONE
    issue("t3b_10_3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b1);
    start = 1'b1; a = 4'd12; b = 4'd5;
    begin
      exp_t e;
      e.tag = "t3b_12_5"; e.a = 4'd12; e.b = 4'd5; e.q = 4'd2; e.r = 4'd2;
      e.dz = 1'b0; e.cyc = cyc + 5 + 4;
      sb.push_back(e);
    end
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain("t3b");

    // 4: reset mid-RUN aborts
    issue("t4_abort", 4'd13, 4'd2, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_busy", int'(busy), 0);
    check("t4_valid", int'(valid), 0);
    check("t4_q", int'(q), 0);
    check("t4_r", int'(r), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("t4_6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b1);
    drain("t4");

    // 5: divide by zero
    issue("t5_5_0", 4'd5, 4'd0, 4'd15, 4'd5, 1'b1);
`ifdef DIVISOR_DBZ_EN
    check("t5_busy_dbz", int'(busy), 0);
`endif
    drain("t5");

    // 6: sweep every pair with b != 0 against a reference model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        issue("t6_sweep", 4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b1);
      end
    end
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
